// File: rtl/seg7_defs.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_defs (package)
//  Description : Shared constants for the seven-segment readback path:
//                active-low segment patterns (g..a) for hex digits 0..F,
//                the all-off blank pattern, and decoder FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_defs;

    // Active-low patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h20;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h27;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h04;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decoder FSM state encodings
    localparam logic [1:0] ST_TRACK  = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_lut.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_lut
//  Description : Combinational reverse lookup of an active-low 7-segment
//                pattern to its hex nibble.
//  Ports       : pattern_i [6:0] - active-low segment pattern (g..a)
//                nibble_o  [3:0] - decoded value (0 when not legal)
//                legal_o         - pattern is one of the 16 digit patterns
//                blank_o         - pattern is all segments off
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_lut
    import seg7_defs::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       legal_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        legal_o  = 1'b1;
        blank_o  = 1'b0;
        case (pattern_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decoder
//  Description : Samples an active-low segment bus, waits for it to hold
//                steady for STABLE_CYCLES samples, then decodes it to a hex
//                nibble delivered over a valid/ready handshake, with blank,
//                illegal-pattern and overrun reporting.
//  Ports       : CLOCK_50        - clock, rising edge
//                RST             - asynchronous active-high reset
//                HEX_IN  [7:0]   - segment bus, bit 7 (DP) ignored
//                READY           - consumer accepts VALUE when VALID&READY
//                VALUE   [3:0]   - decoded nibble
//                VALID           - VALUE pending
//                BLANK           - last accepted pattern was all-off
//                ERR             - sticky illegal-pattern flag
//                ERR_CNT [W-1:0] - saturating illegal-pattern count
//                OVR             - sticky overrun flag
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_defs::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 RST,
    input  logic [7:0]           HEX_IN,
    input  logic                 READY,
    output logic [3:0]           VALUE,
    output logic                 VALID,
    output logic                 BLANK,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 OVR
);

    localparam logic [7:0]           c_stable  = 8'(STABLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

    // Decimal point carries no digit information.
    logic w_unused_dp;
    assign w_unused_dp = HEX_IN[7];

    logic [6:0]           smp_q, smp_prev_q, last_q;
    logic [6:0]           last_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [1:0]           state_q, state_d;
    logic [3:0]           value_q, value_d;
    logic                 valid_q, valid_d;
    logic                 blank_q, blank_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 ovr_q, ovr_d;

    logic [3:0]           w_nibble;
    logic                 w_legal;
    logic                 w_blank;

    // In ACCEPT, smp_prev_q holds the sample that completed the stable run,
    // even if the bus has already moved on in smp_q.
    seg7_pattern_lut u_lut (
        .pattern_i (smp_prev_q),
        .nibble_o  (w_nibble),
        .legal_o   (w_legal),
        .blank_o   (w_blank)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        value_d   = value_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        ovr_d     = ovr_q;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_TRACK: begin
                if (smp_q == smp_prev_q) begin
                    if (cnt_q != c_stable) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = 8'd1;
                end
                if (cnt_d == c_stable) begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                state_d = ST_HOLD;
                // Same pattern as last time: suppress duplicate delivery.
                if (smp_prev_q != last_q) begin
                    last_d = smp_prev_q;
                    if (w_legal) begin
                        value_d = w_nibble;
                        valid_d = 1'b1;
                        blank_d = 1'b0;
                        // Consumer taking the old value this cycle is no overrun.
                        if (valid_q && !READY) begin
                            ovr_d = 1'b1;
                        end
                    end else if (w_blank) begin
                        blank_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != c_err_max) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (smp_q != last_q) begin
                    state_d = ST_TRACK;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = ST_TRACK;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            smp_q      <= SEG_BLANK;
            smp_prev_q <= SEG_BLANK;
            last_q     <= SEG_BLANK;
            cnt_q      <= 8'd0;
            state_q    <= ST_TRACK;
            value_q    <= 4'h0;
            valid_q    <= 1'b0;
            blank_q    <= 1'b1;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            smp_q      <= HEX_IN[6:0];
            smp_prev_q <= smp_q;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign VALUE   = value_q;
    assign VALID   = valid_q;
    assign BLANK   = blank_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
    assign OVR     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_hex_decoder
//  Description : Self-checking bench for seg7_hex_decoder. Directed steps
//                for reset, latency, handshake and overrun, then segment
//                streams checked against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_hex_decoder;

    localparam int STABLE = 4;
    localparam int EW     = 8;

    logic          CLOCK_50 = 1'b0;
    logic          RST      = 1'b1;
    logic [7:0]    HEX_IN   = 8'hFF;
    logic          READY    = 1'b0;
    logic [3:0]    VALUE;
    logic          VALID;
    logic          BLANK;
    logic          ERR;
    logic [EW-1:0] ERR_CNT;
    logic          OVR;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    seg7_hex_decoder #(
        .STABLE_CYCLES (STABLE),
        .ERR_CNT_W     (EW)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .HEX_IN   (HEX_IN),
        .READY    (READY),
        .VALUE    (VALUE),
        .VALID    (VALID),
        .BLANK    (BLANK),
        .ERR      (ERR),
        .ERR_CNT  (ERR_CNT),
        .OVR      (OVR)
    );

    // Digit patterns, index = digit value
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h20, 7'h03, 7'h27, 7'h21, 7'h04, 7'h0E};

    // Model state: deliveries expected vs handshakes seen
    logic [3:0] obs_q [$];
    logic [3:0] exp_q [$];
    logic [6:0] m_last;
    logic [6:0] run_pat;
    int         run_len;
    bit         run_done;
    bit         m_blank;
    int         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, then sample at the falling edge.
    task automatic cyc(input logic [7:0] hex, input logic rdy);
        HEX_IN = hex;
        READY  = rdy;
        @(negedge CLOCK_50);
        if (VALID === 1'b1 && READY === 1'b1) obs_q.push_back(VALUE);
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 16; k++) if (seg_tab[k] == p) return k;
        return -1;
    endfunction

    function automatic void model_accept(input logic [6:0] p);
        int idx;
        if (p != m_last) begin
            m_last = p;
            idx = lookup(p);
            if (idx >= 0) begin
                exp_q.push_back(4'(idx));
                m_blank = 1'b0;
            end else if (p == 7'h7F) begin
                m_blank = 1'b1;
            end else begin
                m_err++;
            end
        end
    endfunction

    // Hold a pattern for len cycles with READY high; contiguous identical
    // patterns form one run, accepted once it spans STABLE samples.
    task automatic seg(input logic [6:0] p, input int len);
        if (p != run_pat) begin
            run_pat  = p;
            run_len  = 0;
            run_done = 1'b0;
        end
        for (int k = 0; k < len; k++) cyc({1'($urandom_range(0, 1)), p}, 1'b1);
        run_len += len;
        if (!run_done && run_len >= STABLE) begin
            run_done = 1'b1;
            model_accept(p);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_handshakes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_value"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_err_cnt"}, 32'(ERR_CNT), 32'((m_err > 255) ? 255 : m_err));
        chk({tag, "_err"},     32'(ERR),     32'(m_err > 0));
        chk({tag, "_blank"},   32'(BLANK),   32'(m_blank));
        chk({tag, "_ovr"},     32'(OVR),     32'd0);
    endtask

    initial begin
        logic [6:0] p;
        logic [6:0] prev_p;
        int         kind;
        int         len;

        // Reset values
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_value",   32'(VALUE),   32'h0);
        chk("rst_valid",   32'(VALID),   32'h0);
        chk("rst_blank",   32'(BLANK),   32'h1);
        chk("rst_err",     32'(ERR),     32'h0);
        chk("rst_err_cnt", 32'(ERR_CNT), 32'h0);
        chk("rst_ovr",     32'(OVR),     32'h0);
        RST = 1'b0;
        repeat (8) cyc(8'hFF, 1'b0);

        // Latency: VALID first high after the 6th cycle of a steady pattern
        for (int i = 1; i <= 6; i++) begin
            cyc(8'h24, 1'b0);
            chk("latency_valid", 32'(VALID), 32'(i == 6));
        end
        chk("latency_value", 32'(VALUE), 32'h2);
        cyc(8'h24, 1'b1);
        chk("ready_clears_valid", 32'(VALID), 32'h0);

        // Overrun: two values with no consumer
        repeat (6) cyc(8'h30, 1'b0);
        chk("ovr_first_valid", 32'(VALID), 32'h1);
        chk("ovr_first_value", 32'(VALUE), 32'h3);
        chk("ovr_first_flag",  32'(OVR),   32'h0);
        repeat (6) cyc(8'h12, 1'b0);
        chk("ovr_second_value", 32'(VALUE), 32'h5);
        chk("ovr_second_flag",  32'(OVR),   32'h1);
        chk("ovr_second_valid", 32'(VALID), 32'h1);

        // Asynchronous reset with a value still pending
        #3 RST = 1'b1;
        #1;
        chk("async_rst_value", 32'(VALUE), 32'h0);
        chk("async_rst_valid", 32'(VALID), 32'h0);
        chk("async_rst_blank", 32'(BLANK), 32'h1);
        chk("async_rst_ovr",   32'(OVR),   32'h0);
        repeat (3) cyc(8'hFF, 1'b1);
        chk("rst_held_valid", 32'(VALID), 32'h0);
        RST = 1'b0;
        repeat (8) cyc(8'hFF, 1'b0);

        // Accept coinciding with a handshake: no overrun, new value pending
        repeat (6) cyc(8'h19, 1'b0);
        chk("coinc_first_valid", 32'(VALID), 32'h1);
        chk("coinc_first_value", 32'(VALUE), 32'h4);
        repeat (5) cyc(8'h02, 1'b0);
        chk("coinc_pre_value", 32'(VALUE), 32'h4);
        cyc(8'h02, 1'b1);
        chk("coinc_valid", 32'(VALID), 32'h1);
        chk("coinc_value", 32'(VALUE), 32'h6);
        chk("coinc_ovr",   32'(OVR),   32'h0);
        cyc(8'h02, 1'b1);
        chk("coinc_drain", 32'(VALID), 32'h0);

        // Model-checked streams from here on
        m_last   = 7'h02;
        run_pat  = 7'h02;
        run_len  = 100;
        run_done = 1'b1;
        m_blank  = 1'b0;
        m_err    = 0;
        obs_q.delete();
        exp_q.delete();

        for (int k = 0; k < 16; k++) begin
            seg(seg_tab[k], 6);
            seg(7'h7F, 6);
        end
        model_check("sweep");

        seg(7'h79, 3);
        seg(7'h7F, 6);
        model_check("glitch");

        seg(7'h12, 6);
        seg(7'h7F, 6);
        seg(7'h12, 6);
        model_check("rearm");
        seg(7'h7F, 6);
        seg(7'h12, 24);
        model_check("held");

        // Random segments: either clearly short or clearly long
        prev_p = 7'h12;
        for (int n = 0; n < 200; n++) begin
            do begin
                kind = int'($urandom_range(0, 3));
                if (kind == 0)      p = seg_tab[$urandom_range(0, 15)];
                else if (kind == 1) p = 7'h7F;
                else                p = 7'($urandom);
            end while (p == prev_p);
            len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, STABLE - 1))
                                              : int'($urandom_range(STABLE + 2, STABLE + 5));
            seg(p, len);
            prev_p = p;
        end
        seg(7'h7F, 6);
        model_check("random");

        // Illegal pattern repeated until the counter saturates
        for (int n = 0; n < 300; n++) begin
            seg(7'h55, 6);
            seg(7'h7F, 6);
        end
        model_check("illegal");
        chk("err_cnt_saturated", 32'(ERR_CNT), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
